// File: rtl/sha_pkg.sv
// Shared SHA-256 constants, accumulator state encoding and per-lane chain-select codes.
// Word 0 of SHA256_IV sits in the least significant bits.
package sha_pkg;

  localparam int SHA_WIDTH = 32;
  localparam int SHA_WORDS = 8;

  localparam logic [SHA_WORDS*SHA_WIDTH-1:0] SHA256_IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } acc_state_t;

  // Source of the next chaining word in every lane.
  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_IV   = 2'd1,
    SEL_MID  = 2'd2,
    SEL_SUM  = 2'd3
  } lane_sel_t;

endpackage

// File: rtl/hash_word_acc.sv
// One chaining-word lane: chain register, modular adder, and midstate and digest capture.
// The lanes have no carry path between them; all control comes from the top-level FSM.
module hash_word_acc
  import sha_pkg::*;
#(
  parameter int                WIDTH   = SHA_WIDTH,
  parameter logic [WIDTH-1:0]  IV_WORD = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  lane_sel_t        sel,
  input  logic             mid_capture,
  input  logic             digest_load,
  input  logic [WIDTH-1:0] add_word,
  output logic [WIDTH-1:0] chain,
  output logic [WIDTH-1:0] digest
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] mid;
  logic [WIDTH-1:0] chain_next;

  // Natural truncation gives the required addition modulo 2^WIDTH.
  assign sum = chain + add_word;

  always_comb begin
    chain_next = chain;
    case (sel)
      SEL_IV:  chain_next = IV_WORD;
      SEL_MID: chain_next = mid;
      SEL_SUM: chain_next = sum;
      default: chain_next = chain;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain  <= IV_WORD;
      mid    <= '0;
      digest <= '0;
    end else begin
      chain <= chain_next;
      if (mid_capture) begin
        mid <= sum;
      end
      if (digest_load) begin
        digest <= sum;
      end
    end
  end

endmodule

// File: rtl/hash_state_acc.sv
// SHA-256 chaining-state accumulator: one FSM plus block and pass counters driving WORDS lanes.
// Handles multi-block messages, midstate capture/restore, an optional second pass, and the digest handshake.
module hash_state_acc
  import sha_pkg::*;
#(
  parameter int                        WIDTH  = SHA_WIDTH,
  parameter int                        WORDS  = SHA_WORDS,
  parameter logic [WORDS*WIDTH-1:0]    IV     = SHA256_IV,
  parameter int                        DOUBLE = 1,
  parameter int                        CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   init_i,
  input  logic                   mid_load_i,
  input  logic                   add_valid_i,
  output logic                   add_ready_o,
  input  logic [WORDS*WIDTH-1:0] add_data_i,
  input  logic                   add_last_i,
  output logic [WORDS*WIDTH-1:0] chain_o,
  output logic                   mid_valid_o,
  output logic [CNT_W-1:0]       blk_cnt_o,
  output logic                   pass_o,
  output logic                   digest_valid_o,
  input  logic                   digest_ready_i,
  output logic [WORDS*WIDTH-1:0] digest_o
);

  acc_state_t       state, state_next;
  logic [CNT_W-1:0] blk_cnt, blk_cnt_next;
  logic             pass, pass_next;
  logic             mid_valid, mid_valid_next;
  logic             digest_valid, digest_valid_next;
  lane_sel_t        sel;
  logic             mid_capture;
  logic             digest_load;
  logic             accept;

  assign add_ready_o    = (state == ST_ACCUM);
  assign accept         = add_valid_i && add_ready_o;
  assign blk_cnt_o      = blk_cnt;
  assign pass_o         = pass;
  assign mid_valid_o    = mid_valid;
  assign digest_valid_o = digest_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      blk_cnt      <= '0;
      pass         <= 1'b0;
      mid_valid    <= 1'b0;
      digest_valid <= 1'b0;
    end else begin
      state        <= state_next;
      blk_cnt      <= blk_cnt_next;
      pass         <= pass_next;
      mid_valid    <= mid_valid_next;
      digest_valid <= digest_valid_next;
    end
  end

  always_comb begin
    state_next        = state;
    blk_cnt_next      = blk_cnt;
    pass_next         = pass;
    mid_valid_next    = mid_valid;
    digest_valid_next = digest_valid;
    sel               = SEL_HOLD;
    mid_capture       = 1'b0;
    digest_load       = 1'b0;

    if (init_i) begin
      sel               = SEL_IV;
      pass_next         = 1'b0;
      blk_cnt_next      = '0;
      digest_valid_next = 1'b0;
      state_next        = ST_ACCUM;
    end else if (mid_load_i && mid_valid) begin
      // The restored midstate already covers the first block of the message.
      sel               = SEL_MID;
      pass_next         = 1'b0;
      blk_cnt_next      = CNT_W'(1);
      digest_valid_next = 1'b0;
      state_next        = ST_ACCUM;
    end else if (accept) begin
      if (!add_last_i) begin
        sel = SEL_SUM;
        if (blk_cnt != {CNT_W{1'b1}}) begin
          blk_cnt_next = blk_cnt + CNT_W'(1);
        end
        if (!pass && (blk_cnt == '0)) begin
          mid_capture    = 1'b1;
          mid_valid_next = 1'b1;
        end
      end else if ((DOUBLE != 0) && !pass) begin
        // Pass-1 digest goes straight to the compressor; pass 2 restarts from the IV.
        sel          = SEL_IV;
        pass_next    = 1'b1;
        blk_cnt_next = '0;
      end else begin
        sel               = SEL_IV;
        digest_load       = 1'b1;
        digest_valid_next = 1'b1;
        pass_next         = 1'b0;
        blk_cnt_next      = '0;
        state_next        = ST_DONE;
      end
    end else if ((state == ST_DONE) && digest_ready_i) begin
      digest_valid_next = 1'b0;
      state_next        = ST_IDLE;
    end
  end

  for (genvar gi = 0; gi < WORDS; gi++) begin : g_lane
    hash_word_acc #(
      .WIDTH   (WIDTH),
      .IV_WORD (IV[gi*WIDTH +: WIDTH])
    ) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .sel         (sel),
      .mid_capture (mid_capture),
      .digest_load (digest_load),
      .add_word    (add_data_i[gi*WIDTH +: WIDTH]),
      .chain       (chain_o[gi*WIDTH +: WIDTH]),
      .digest      (digest_o[gi*WIDTH +: WIDTH])
    );
  end

endmodule

// File: doc/hash_state_acc.md
Name: hash_state_acc

Overview:
- Parametrised chaining-state accumulator for the SHA-256 mining datapath; holds all WORDS chaining words (H0..H7) in one block.
- Feeds the current chaining value to the compression core and adds each compression result word-wise, modulo 2^WIDTH.
- Supports multi-block messages, midstate capture/restore for nonce sweeps, and a DOUBLE mode where the pass-1 digest is followed by a second pass from the IV (Bitcoin double SHA-256).
- Emits the final digest through a valid/ready handshake.

Parameters:
- WIDTH, 32, bits per chaining word.
- WORDS, 8, number of chaining words.
- IV, {6a09e667,bb67ae85,3c6ef372,a54ff53a,510e527f,9b05688c,1f83d9ab,5be0cd19}, WORDS*WIDTH initial value; word 0 in the LSBs.
- DOUBLE, 1, 1 = second hash pass after pass 1; 0 = single pass.
- CNT_W, 8, block counter width.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- init_i  in  1  start new message: load IV, clear counters.
- mid_load_i  in  1  restore the saved midstate as the chaining value.
- add_valid_i  in  1  compression result valid.
- add_ready_o  out  1  accumulator can accept a result.
- add_data_i  in  WORDS*WIDTH  compression result, word 0 in the LSBs.
- add_last_i  in  1  the accepted result is the final block of the current pass.
- chain_o  out  WORDS*WIDTH  current chaining value, fed to the compressor.
- mid_valid_o  out  1  the midstate register holds a valid capture.
- blk_cnt_o  out  CNT_W  blocks accepted in the current pass.
- pass_o  out  1  0 = pass 1, 1 = pass 2.
- digest_valid_o  out  1  final digest available.
- digest_ready_i  in  1  consumer accepts the digest.
- digest_o  out  WORDS*WIDTH  final digest.

Behaviour:
- Reset (async assert, sync release):
  - chain_o=IV, digest_o=0, midstate=0.
  - mid_valid_o=0, digest_valid_o=0, blk_cnt_o=0, pass_o=0.
  - State IDLE.
- States: IDLE, ACCUM, DONE.
  - add_ready_o = (state==ACCUM); purely combinational from state.
- Accept event: add_valid_i & add_ready_o.
  - sum[i] = chain[i] + add_data[i] for each word, truncated to WIDTH bits; no carry between words.
  - chain_o updates the cycle after an accept; one accept is possible per cycle; no bubbles.
- Accept with add_last_i=0:
  - chain<=sum.
  - blk_cnt+=1, saturating at 2^CNT_W-1.
  - If pass==0 and blk_cnt==0: midstate<=sum and mid_valid<=1.
- Accept with add_last_i=1, pass==0, DOUBLE=1:
  - chain<=IV, pass<=1, blk_cnt<=0; stay in ACCUM.
  - The pass-1 digest (sum) is the data the compressor pads for pass 2; this block does not store it.
  - No midstate capture on a last block.
- Accept with add_last_i=1 in pass 2, or with DOUBLE=0:
  - digest_o<=sum, digest_valid<=1, chain<=IV, pass<=0, blk_cnt<=0; go to DONE.
- DONE:
  - digest_o and digest_valid held stable until digest_ready_i=1.
  - The cycle after the handshake, digest_valid<=0 and the state goes to IDLE.
- init_i (any state):
  - chain<=IV, pass<=0, blk_cnt<=0, digest_valid<=0; go to ACCUM.
  - midstate and mid_valid are kept.
  - Any accept in the same cycle is discarded.
- mid_load_i (any state, only when mid_valid=1):
  - chain<=midstate, blk_cnt<=1, pass<=0, digest_valid<=0; go to ACCUM.
  - Ignored when mid_valid=0.
- Priority: rst_n > init_i > mid_load_i > accept > digest handshake.
- Reset mid-operation aborts everything, including the midstate.
- add_valid_i in IDLE/DONE: ignored, not accepted.
- add_data_i is only sampled on an accept.

Decomposition:
- Shared package sha_pkg holds:
  - constants SHA_WIDTH=32, SHA_WORDS=8, SHA256_IV;
  - the state encoding (IDLE=0, ACCUM=1, DONE=2).
- Sub-module hash_word_acc: one word lane containing the chain register, adder and IV/midstate/sum select. It is instantiated WORDS times by a generate loop; the FSM and counters stay in the top level.

Test Plan:
- Reset, then init, then one accept with add_data word0=95f6199a, others 0, last=1, DOUBLE=0 -> digest_o word0=00000001 (wraps, no carry into word1); word1..7=IV; digest_valid=1 one cycle after the accept; chain_o=IV.
- DOUBLE=1, init, accept A (last=0), accept B (last=1), accept C (last=1) -> midstate=IV+A; pass_o toggles 0→1 after B; digest_o=IV+C; blk_cnt_o=0 at end.
- After the previous test: mid_load_i, then accept B (last=1), then accept C (last=1) -> same digest as before; blk_cnt_o=1 after mid_load.
- Digest held with digest_ready_i=0 for 5 cycles -> digest_o stable, add_ready_o=0, add_valid_i ignored; ready=1 -> IDLE the next cycle.
- init_i and an accept asserted in the same cycle -> chain_o=IV, blk_cnt_o=0, accept dropped; mid_load_i with mid_valid=0 -> no state change.
- rst_n pulsed low mid-ACCUM (asynchronously, between clock edges) -> outputs reach reset values immediately; mid_valid_o=0; add_ready_o=0.
